gravity_multi_source: RTL and testbench

//  Per-player autodrop ("gravity") generator for NUM_PLAYERS boards. Emits single-cycle auto_drop pulses at a

---
 rtl/gravity_multi_source_pkg.sv | 34 +++
 rtl/gravity_multi_source_channel.sv | 69 ++++++
 rtl/gravity_multi_source.sv | 54 +++++
 tb/tb_gravity_multi_source.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gravity_multi_source_pkg.sv
// Shared gravity constants: drop-period table, counter width, screen enum.
// period_of() applies the simulation shift and clamps the result to >= 1.
package gravity_multi_source_pkg;

  localparam int GRAVITY_CNT_W = 26;
  localparam int GRAVITY_DEPTH = 15;

  localparam logic [GRAVITY_CNT_W-1:0] GRAVITY_TABLE [GRAVITY_DEPTH] = '{
    26'd40000000, 26'd36000000, 26'd31500000, 26'd27500000,
    26'd23500000, 26'd19000000, 26'd15000000, 26'd11000000,
    26'd6500000,  26'd5000000,  26'd4000000,  26'd3500000,
    26'd2500000,  26'd1500000,  26'd1000000
  };

  typedef enum logic [1:0] {
    SCR_TITLE,
    SCR_SPRINT,
    SCR_MP,
    SCR_RESULT
  } game_screens_t;

  function automatic logic [GRAVITY_CNT_W-1:0] period_of(
    input int lvl,
    input int shift
  );
    logic [GRAVITY_CNT_W-1:0] t;
    t = '0;
    for (int i = 0; i < GRAVITY_DEPTH; i++)
      if (lvl == i) t = GRAVITY_TABLE[i] >> shift;
    if (t == '0) t = GRAVITY_CNT_W'(1);
    return t;
  endfunction

endpackage

// File: rtl/gravity_multi_source_channel.sv
// One gravity channel: level register, level_up pulse, period down-counter.
// freeze holds the counter and defers any level_up until it drops.
module gravity_channel
  import gravity_multi_source_pkg::*;
#(
  parameter int LINES_PER_LEVEL = 15,
  parameter int NUM_LEVELS      = 15,
  parameter int PERIOD_SHIFT    = 0,
  parameter int LVL_W           = $clog2(NUM_LEVELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             soft_drop,
  input  logic             drop_valid,
  input  logic [9:0]       lines_cleared,
  input  logic             freeze,
  output logic             auto_drop,
  output logic [LVL_W-1:0] level,
  output logic             level_up
);

  logic [GRAVITY_CNT_W-1:0] count;
  logic [GRAVITY_CNT_W-1:0] reload;
  logic [LVL_W-1:0]         lvl_next;
  logic                     lvl_pend;
  logic                     expire;
  logic                     rise;
  int                       lvl_q;

  always_comb begin
    lvl_q = int'(lines_cleared) / LINES_PER_LEVEL;
    if (lvl_q > NUM_LEVELS - 1) lvl_q = NUM_LEVELS - 1;
    lvl_next = LVL_W'(lvl_q);
  end

  assign reload = period_of(int'(level), PERIOD_SHIFT) - GRAVITY_CNT_W'(1);
  assign expire = (count == '0);
  assign rise   = (lvl_next > level);

  assign auto_drop = ~rst & ~freeze & active & expire
                   & drop_valid & ~soft_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= period_of(0, PERIOD_SHIFT) - GRAVITY_CNT_W'(1);
      level    <= '0;
      level_up <= 1'b0;
      lvl_pend <= 1'b0;
    end else begin
      level <= lvl_next;
      if (freeze) begin
        level_up <= 1'b0;
        if (rise) lvl_pend <= 1'b1;
      end else begin
        level_up <= lvl_pend | rise;
        lvl_pend <= 1'b0;
      end
      // reload reads the current level, so a level change waits for expiry
      if (!freeze) begin
        if (!active || soft_drop || expire)
          count <= reload;
        else
          count <= count - GRAVITY_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gravity_multi_source.sv
// Per-player autodrop generator; one gravity_channel per player.
// Define GRAVITY_PAUSE_EN to add the global pause input.
module gravity_multi_source
  import gravity_multi_source_pkg::*;
#(
  parameter  int NUM_PLAYERS     = 2,
  parameter  int LINES_PER_LEVEL = 15,
  parameter  int NUM_LEVELS      = 15,
  parameter  int PERIOD_SHIFT    = 0,
  localparam int LVL_W           = $clog2(NUM_LEVELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PLAYERS-1:0]       active,
  input  logic [NUM_PLAYERS-1:0]       soft_drop,
  input  logic [NUM_PLAYERS-1:0]       drop_valid,
  input  logic [NUM_PLAYERS*10-1:0]    lines_cleared,
`ifdef GRAVITY_PAUSE_EN
  input  logic                         pause,
`endif
  output logic [NUM_PLAYERS-1:0]       auto_drop,
  output logic [NUM_PLAYERS*LVL_W-1:0] level,
  output logic [NUM_PLAYERS-1:0]       level_up
);

  logic freeze;

`ifdef GRAVITY_PAUSE_EN
  assign freeze = pause;
`else
  assign freeze = 1'b0;
`endif

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
    gravity_channel #(
      .LINES_PER_LEVEL (LINES_PER_LEVEL),
      .NUM_LEVELS      (NUM_LEVELS),
      .PERIOD_SHIFT    (PERIOD_SHIFT),
      .LVL_W           (LVL_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .active        (active[i]),
      .soft_drop     (soft_drop[i]),
      .drop_valid    (drop_valid[i]),
      .lines_cleared (lines_cleared[10*i +: 10]),
      .freeze        (freeze),
      .auto_drop     (auto_drop[i]),
      .level         (level[LVL_W*i +: LVL_W]),
      .level_up      (level_up[i])
    );
  end

endmodule

// File: tb/tb_gravity_multi_source.sv
// Randomized bench for gravity_multi_source against a due-time model.
// Model tracks the absolute cycle of each channel's next expiry.
module tb_gravity_multi_source;

  localparam int NP = 2;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   active;
  logic [NP-1:0]   soft_drop;
  logic [NP-1:0]   drop_valid;
  logic [NP*10-1:0] lines_cleared;
  logic            pause;
  logic [NP-1:0]   auto_drop;
  logic [NP*LW-1:0] level;
  logic [NP-1:0]   level_up;

  always #10 clk = ~clk;

  gravity_multi_source #(
    .NUM_PLAYERS     (NP),
    .LINES_PER_LEVEL (15),
    .NUM_LEVELS      (15),
    .PERIOD_SHIFT    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .active        (active),
    .soft_drop     (soft_drop),
    .drop_valid    (drop_valid),
    .lines_cleared (lines_cleared),
`ifdef GRAVITY_PAUSE_EN
    .pause         (pause),
`endif
    .auto_drop     (auto_drop),
    .level         (level),
    .level_up      (level_up)
  );

  int unsigned tbl [15] = '{40000000, 36000000, 31500000, 27500000,
                            23500000, 19000000, 15000000, 11000000,
                            6500000, 5000000, 4000000, 3500000,
                            2500000, 1500000, 1000000};

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int ln   [NP];
  int due  [NP];
  int mlvl [NP];
  int mlup [NP];
  int mpnd [NP];
  int cnt0 = 0;

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int per(int l);
    int p;
    p = int'(tbl[l] / 65536);
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NP; c++) begin
      mlvl[c] = 0;
      mlup[c] = 0;
      mpnd[c] = 0;
      due[c]  = cyc + per(0);
    end
  endtask

  task automatic step();
    int nxt;
    int exp_drop;
    lines_cleared = {10'(ln[1]), 10'(ln[0])};
    #1;
    for (int c = 0; c < NP; c++) begin
      exp_drop = (!rst && !pause && active[c] && cyc == due[c]
                  && drop_valid[c] && !soft_drop[c]) ? 1 : 0;
      check($sformatf("auto_drop%0d", c), int'(auto_drop[c]), exp_drop);
      check($sformatf("level%0d", c), int'(level[LW*c +: LW]), mlvl[c]);
      check($sformatf("level_up%0d", c), int'(level_up[c]), mlup[c]);
    end
    if (auto_drop[0]) cnt0++;
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < NP; c++) begin
        nxt = ln[c] / 15;
        if (nxt > 14) nxt = 14;
        if (pause) begin
          mlup[c] = 0;
          if (nxt > mlvl[c]) mpnd[c] = 1;
          due[c] = due[c] + 1;
        end else begin
          mlup[c] = (mpnd[c] != 0 || nxt > mlvl[c]) ? 1 : 0;
          mpnd[c] = 0;
          if (!active[c] || soft_drop[c] || cyc == due[c])
            due[c] = cyc + per(mlvl[c]);
        end
        mlvl[c] = nxt;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1;
    active = '0;
    soft_drop = '0;
    drop_valid = '0;
    pause = 1'b0;
    ln[0] = 0;
    ln[1] = 0;
    model_reset();
    @(posedge clk);
    #1;
    run(3);
    rst = 1'b0;
    run(2);

    // steady gravity on channel 0
    active[0] = 1'b1;
    drop_valid = 2'b11;
    cnt0 = 0;
    run(1900);
    check("s1_pulses", cnt0, 3);

    // soft drop mid-period, then on an expiry cycle
    run(300);
    soft_drop[0] = 1'b1;
    step();
    soft_drop[0] = 1'b0;
    run(700);
    for (int k = 0; k < 700 && due[0] != cyc; k++) step();
    soft_drop[0] = 1'b1;
    step();
    soft_drop[0] = 1'b0;
    run(50);

    // level step mid-period
    ln[0] = 14;
    run(2);
    ln[0] = 15;
    run(2);
    check("s3_level", int'(level[LW-1:0]), 1);
    run(1300);

    // saturation, then new game
    ln[0] = 1023;
    run(2);
    check("s4_level_max", int'(level[LW-1:0]), 14);
    run(100);
    ln[0] = 0;
    run(2);
    check("s4_level_min", int'(level[LW-1:0]), 0);

    // blocked drop and active restart
    drop_valid[0] = 1'b0;
    run(700);
    drop_valid[0] = 1'b1;
    active[0] = 1'b0;
    run(5);
    active[0] = 1'b1;
    cnt0 = 0;
    run(620);
    check("s5_restart", cnt0, 1);

`ifdef GRAVITY_PAUSE_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    active = 2'b11;
    run(200);
    pause = 1'b1;
    ln[1] = 20;
    run(100);
    pause = 1'b0;
    run(800);
`endif

    // randomized mix on both channels
    for (int k = 0; k < 5000; k++) begin
      rst = ($urandom_range(0, 1499) == 0);
      for (int c = 0; c < NP; c++) begin
        if ($urandom_range(0, 199) == 0) active[c] = ~active[c];
        soft_drop[c]  = ($urandom_range(0, 99) == 0);
        drop_valid[c] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) ln[c] = ln[c] + 3;
        if ($urandom_range(0, 999) == 0) ln[c] = 0;
        if (ln[c] > 1023) ln[c] = 1023;
      end
`ifdef GRAVITY_PAUSE_EN
      if ($urandom_range(0, 299) == 0) pause = ~pause;
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
